magnitude_comparator_pipelined: RTL

Pipelined, back-pressure-aware magnitude comparator built as a SPLIT-ary reduction tree with a register slice inserted every STAGE tree levels. It is the registered successor of the combinational tree comparator, intended for wide datapaths where a single-cycle tree misses timing. Transactions enter and leave through valid/ready handshakes. Each accepted operand pair produces one ordered result: a greater, b greater, or equal.

---
 rtl/magnitude_comparator_pipelined.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/magnitude_comparator_pipelined.sv
// Pipelined SPLIT-ary magnitude comparator (a>b, b>a, equal); register slice every STAGE tree levels.
// Latency: N = ceil(L/STAGE) cycles, L = ceil(log_SPLIT(WIDTH)); one result per cycle; outputs registered.
// Backpressure: per-slice valid with bubble collapse; i_rdy is combinational from o_rdy. Optional macro MAGNITUDE_COMPARATOR_PIPELINED_SIGNED_EN adds i_sgn.

// One tree node: reduces SPLIT (a,b) flag pairs to one pair, highest-index non-equal pair wins.
module magnitude_comparator_pipelined_node #(
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0
) (
    input  logic [SPLIT-1:0] i_a,
    input  logic [SPLIT-1:0] i_b,
    output logic             o_a,
    output logic             o_b
);

    if (IMPLEMENTATION == 0) begin : g_scan
        // LSB-to-MSB scan: a later (more significant) non-equal pair overrides earlier ones
        always_comb begin
            o_a = 1'b0;
            o_b = 1'b0;
            for (int i = 0; i < SPLIT; i++) begin
                if (i_a[i] | i_b[i]) begin
                    o_a = i_a[i];
                    o_b = i_b[i];
                end
            end
        end
    end else begin : g_mask
        logic [SPLIT-1:0] w_hi;
        // one-hot mask of the most significant non-equal child, then AND-OR select
        always_comb begin
            logic v_seen;
            v_seen = 1'b0;
            w_hi   = '0;
            for (int i = SPLIT - 1; i >= 0; i--) begin
                w_hi[i] = (i_a[i] | i_b[i]) & ~v_seen;
                v_seen  = v_seen | i_a[i] | i_b[i];
            end
        end
        assign o_a = |(w_hi & i_a);
        assign o_b = |(w_hi & i_b);
    end

endmodule

module magnitude_comparator_pipelined #(
    parameter int WIDTH          = 32,
    parameter int SPLIT          = 2,
    parameter int STAGE          = 1,
    parameter int IMPLEMENTATION = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    output logic             i_rdy,
    input  logic             i_sgn,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_vld,
    input  logic             o_rdy,
    output logic             o_a,
    output logic             o_b
);

    function automatic int f_levels(input int w, input int s);
        int  l;
        longint p;
        l = 0;
        p = 1;
        while (p < w) begin
            p = p * s;
            l = l + 1;
        end
        return l;
    endfunction

    localparam int L     = f_levels(WIDTH, SPLIT);
    localparam int POWER = SPLIT ** L;
    localparam int N     = (L + STAGE - 1) / STAGE;

    logic [POWER-1:0] w_pa, w_pb;
    logic [N:1]       r_vld;
    logic [N:1]       w_ld;
    logic [N:1]       w_in_vld;
    logic [N:1]       w_en;

    assign w_pa = POWER'(i_a);
    assign w_pb = POWER'(i_b);

    // slice j may load when it or any slice below it is empty, or the output is being drained
    always_comb begin
        logic v_full;
        v_full = 1'b1;
        w_ld   = '0;
        for (int j = N; j >= 1; j--) begin
            v_full  = v_full & r_vld[j];
            w_ld[j] = o_rdy | ~v_full;
        end
    end

    // valid entering each slice: the input handshake for slice 1, the previous slice otherwise
    always_comb begin
        w_in_vld    = '0;
        w_in_vld[1] = i_vld;
        for (int j = 2; j <= N; j++) begin
            w_in_vld[j] = r_vld[j-1];
        end
    end

    // data registers only capture real transactions so they hold through bubbles
    assign w_en  = w_ld & w_in_vld;
    assign i_rdy = w_ld[1];

    // slice valids advance on load; a load with nothing incoming inserts a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            for (int j = 1; j <= N; j++) begin
                if (w_ld[j]) begin
                    r_vld[j] <= w_in_vld[j];
                end
            end
        end
    end

`ifdef MAGNITUDE_COMPARATOR_PIPELINED_SIGNED_EN
    // Sign handling is reduced up front to "a wins" / "b wins" overrides that ride with the data.
    logic w_ovra_in, w_ovrb_in, w_ovra_n, w_ovrb_n;
    assign w_ovra_in = i_sgn & ~i_a[WIDTH-1] &  i_b[WIDTH-1];
    assign w_ovrb_in = i_sgn &  i_a[WIDTH-1] & ~i_b[WIDTH-1];

    if (N > 1) begin : g_sgn_pipe
        logic [N-1:1] r_ovra, r_ovrb;
        // carry the overrides through every slice ahead of the output slice
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_ovra <= '0;
                r_ovrb <= '0;
            end else begin
                if (w_en[1]) begin
                    r_ovra[1] <= w_ovra_in;
                    r_ovrb[1] <= w_ovrb_in;
                end
                for (int j = 2; j < N; j++) begin
                    if (w_en[j]) begin
                        r_ovra[j] <= r_ovra[j-1];
                        r_ovrb[j] <= r_ovrb[j-1];
                    end
                end
            end
        end
        assign w_ovra_n = r_ovra[N-1];
        assign w_ovrb_n = r_ovrb[N-1];
    end else begin : g_sgn_direct
        assign w_ovra_n = w_ovra_in;
        assign w_ovrb_n = w_ovrb_in;
    end
`else
    // unsigned-only build: i_sgn has no function
    logic w_unused_sgn;
    assign w_unused_sgn = i_sgn;
`endif

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int CNT   = POWER / (SPLIT ** k);
        localparam bit SLICE = ((k % STAGE) == 0) || (k == L);
        localparam int SJ    = (k + STAGE - 1) / STAGE;

        logic [CNT*SPLIT-1:0] w_ia, w_ib;
        logic [CNT-1:0]       w_na, w_nb, w_qa, w_qb;

        if (k == 1) begin : g_leaf
            // per-bit flags: a bit set where only a has a 1, b bit where only b has a 1
            assign w_ia = w_pa & ~w_pb;
            assign w_ib = ~w_pa & w_pb;
        end else begin : g_inner
            assign w_ia = g_lvl[k-1].w_qa;
            assign w_ib = g_lvl[k-1].w_qb;
        end

        for (genvar n = 0; n < CNT; n++) begin : g_node
            magnitude_comparator_pipelined_node #(
                .SPLIT          (SPLIT),
                .IMPLEMENTATION (IMPLEMENTATION)
            ) u_node (
                .i_a (w_ia[n*SPLIT +: SPLIT]),
                .i_b (w_ib[n*SPLIT +: SPLIT]),
                .o_a (w_na[n]),
                .o_b (w_nb[n])
            );
        end

        if (SLICE) begin : g_slice
            logic [CNT-1:0] w_da, w_db, r_qa, r_qb;
            if (k == L) begin : g_out
`ifdef MAGNITUDE_COMPARATOR_PIPELINED_SIGNED_EN
                // differing MSBs under signed compare: the non-negative operand wins
                assign w_da = w_ovra_n ? 1'b1 : (w_ovrb_n ? 1'b0 : w_na);
                assign w_db = w_ovrb_n ? 1'b1 : (w_ovra_n ? 1'b0 : w_nb);
`else
                assign w_da = w_na;
                assign w_db = w_nb;
`endif
            end else begin : g_mid
                assign w_da = w_na;
                assign w_db = w_nb;
            end

            // slice register for this level's flag vectors
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_qa <= '0;
                    r_qb <= '0;
                end else if (w_en[SJ]) begin
                    r_qa <= w_da;
                    r_qb <= w_db;
                end
            end
            assign w_qa = r_qa;
            assign w_qb = r_qb;
        end else begin : g_comb
            assign w_qa = w_na;
            assign w_qb = w_nb;
        end
    end

    assign o_vld = r_vld[N];
    assign o_a   = g_lvl[L].w_qa[0];
    assign o_b   = g_lvl[L].w_qb[0];

endmodule
